axis_pkt_arb_mux: RTL and testbench
===================================

# axis_pkt_arb_mux

Single-clock, packet-granular AXI-Stream multiplexer that merges NUM_SOURCES streams onto one master port. It can be synthesised, has a registered output slice, and offers selectable round-robin or fixed-priority arbitration. A source index rides on m_tdest, and an optional stall timeout force-terminates packets whose source hangs mid-packet. It sits between per-channel packet producers and the shared transmit path, and succeeds the simulation-only FIFO mux.

## Interface
- DATA_WIDTH, 32: tdata width.
- USER_WIDTH, 8: tuser width (≥1).
- NUM_SOURCES, 4: slave ports, 1..16.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT_CYCLES, 128: stall limit, ≥2; used only with the macro below.
- SRC_W (localparam) = max(1, clog2(NUM_SOURCES)).

Ports:
- s_clk  in  1  sole clock for all ports.
- arst  in  1  reset, asynchronous, active-high.
- s_tvalid  in  NUM_SOURCES  per-source valid.
- s_tready  out  NUM_SOURCES  per-source ready.
- s_tlast  in  NUM_SOURCES  per-source last.
- s_tuser  in  USER_WIDTH*NUM_SOURCES  packed, source i at [i*USER_WIDTH +: USER_WIDTH].
- s_tdata  in  DATA_WIDTH*NUM_SOURCES  packed likewise.
- m_tvalid, m_tlast  out  1  registered.
- m_tready  in  1.
- m_tuser  out  USER_WIDTH; m_tdata  out  DATA_WIDTH; m_tdest  out  SRC_W (index of the source of the beat).
- busy  out  1  high whenever state ≠ IDLE.
- timeout_err  out  1  single-cycle pulse on a forced termination.

## Operation
- States: IDLE, PASS, FLUSH, DRAIN. On reset: IDLE, all outputs 0, rr pointer = NUM_SOURCES-1, so source 0 is served first.
- **IDLE:** requests = s_tvalid.
  - If any request is set, register the grant and go to PASS.
  - RR mode: search starts at pointer+1 and wraps modulo NUM_SOURCES. The pointer updates to the granted index.
  - Fixed mode: the lowest set index wins. The pointer is unused.
- **PASS:** only the granted source is connected.
  - s_tready[g] = (!m_tvalid || m_tready). Every other s_tready is 0.
  - Each accepted beat loads the output slice with {tlast, tuser, tdata, g}.
  - When a beat with tlast is accepted, go to IDLE. Arbitration never occurs mid-packet.
- **Output slice:** loads when empty or when m_tready=1. m_tvalid clears when m_tready=1 and nothing is loaded. Outputs hold while m_tvalid && !m_tready.
- NUM_SOURCES=1: the arbiter degenerates to a fixed grant of 0 and m_tdest=0.
- FLUSH and DRAIN are reachable only with the timeout enabled (see Configuration).

## Timing
- Grant latency: request in IDLE at cycle t → PASS, s_tready[g] possibly high at t+1 → first m_tvalid at t+2.
- Throughput in PASS: one beat/cycle while m_tready=1.
- Inter-packet gap: last beat accepted at k → IDLE at k+1 → next grant at k+2. This is one dead input cycle per packet.
- s_tready is combinational from m_tready (forward-register slice). There is no combinational path from s_* to m_*.
- Simultaneous requests in IDLE are resolved within one cycle according to ARB_MODE. A request arriving during PASS waits.
- Backpressure mid-packet holds the grant indefinitely (without the timeout).
- arst mid-packet: outputs clear immediately (asynchronously) and the partial packet is lost. After release, arbitration restarts from IDLE with the reset pointer.

## Configuration
- The macro AXIS_PKT_ARB_MUX_TIMEOUT_EN compiles in the stall timeout.
- **With the macro:**
  - In PASS, a counter increments on each cycle where s_tvalid[g]=0. It clears on any cycle where s_tvalid[g]=1.
  - When the counter reaches TIMEOUT_CYCLES-1 and s_tvalid[g]=0 that cycle, the block pulses timeout_err and enters FLUSH.
  - FLUSH: all s_tready=0. When the slice can load, it loads a marker beat: tlast=1, tdata=0, tuser=all ones, tdest=g. The block then goes to DRAIN.
  - DRAIN: s_tready[g]=1 and accepted beats are discarded. On an accepted tlast, go to IDLE.
- **Without the macro:** no counter; FLUSH and DRAIN are absent; timeout_err is tied 0.

## Structure
- Package axis_pkt_arb_mux_pkg holds:
  - the state enum;
  - ARB_RR=0 and ARB_FIXED=1;
  - the marker tuser constant;
  - the src_width() function, max(1, clog2(n)).
- One sub-module, axis_arb_pick: a combinational arbiter taking (req, pointer, mode) and returning a one-hot grant, its binary index, and an any-request flag.
- The mux, output slice and FSM live in the top level.

## Test plan
- Single source, NUM_SOURCES=4, 8-beat packet on source 2 with m_tready=1 → 8 beats on m, first at t+2, m_tdest=2, tlast only on beat 8.
- RR mode, all four sources continuously offering 2-beat packets → output packet order is 0,1,2,3,0,… with exactly one dead cycle between packets.
- Fixed mode, sources 1 and 3 both requesting → source 1 is always served; source 3 gets the grant only when source 1 idles in IDLE.
- m_tready toggling 1,0,0,1 during a 4-beat packet → no beat lost or duplicated, m_* stable while stalled, and s_tready[g] mirrors the slice availability.
- Timeout enabled, TIMEOUT_CYCLES=16: source 0 sends 3 beats then idles 20 cycles, then sends 2 beats with tlast on the second.
  - Required: timeout_err pulses after 16 idle cycles, then the marker beat (tuser=0xFF, tdata=0, tlast=1).
  - The 2 late beats are dropped, followed by return to IDLE.
- arst asserted mid-packet on beat 3 of 6 → m_tvalid=0 in the same cycle, busy=0. After release, source 0 is granted first.

Source files
------------

// File: rtl/axis_pkt_arb_mux_pkg.sv
// axis_pkt_arb_mux_pkg: shared FSM state type, arbitration-mode codes, the marker
// tuser bit and the source-index width helper for the packet arbiter mux.
package axis_pkt_arb_mux_pkg;

    typedef enum logic [1:0] {IDLE, PASS, FLUSH, DRAIN} state_t;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Replicated across the full tuser width to form the forced-termination marker.
    localparam logic MARKER_TUSER_BIT = 1'b1;

    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_arb_pick.sv
// axis_arb_pick: combinational arbiter, round-robin from ptr+1 or fixed lowest-index.
//   req   in  N   request vector
//   ptr   in  SW  last granted index (round-robin only)
//   fixed in  1   1 = lowest set index wins, 0 = search from ptr+1 with wrap
//   gnt   out N   one-hot grant
//   idx   out SW  binary index of the grant
//   any   out 1   at least one request present
module axis_arb_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          fixed,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    assign any = |req;

    // Walk candidates from lowest to highest priority so the last hit is the winner.
    always_comb begin : pick
        logic [SW-1:0] c;
        gnt = '0;
        idx = '0;
        c   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            c = fixed ? SW'(k) : SW'((int'(ptr) + 1 + k) % N);
            if (req[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/axis_pkt_arb_mux.sv
// axis_pkt_arb_mux: packet-granular AXI-Stream mux with registered output slice.
//   s_clk, arst (async, active-high)
//   s_tvalid/s_tready/s_tlast [NUM_SOURCES], s_tuser/s_tdata packed per source
//   m_tvalid/m_tlast/m_tuser/m_tdata/m_tdest (registered), m_tready
//   busy        : FSM not in IDLE
//   timeout_err : one-cycle pulse on a forced packet termination
// Optional stall timeout compiled in with AXIS_PKT_ARB_MUX_TIMEOUT_EN.
module axis_pkt_arb_mux
    import axis_pkt_arb_mux_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int USER_WIDTH     = 8,
    parameter  int NUM_SOURCES    = 4,
    parameter  int ARB_MODE       = ARB_RR,
    parameter  int TIMEOUT_CYCLES = 128,
    localparam int SRC_W          = src_width(NUM_SOURCES)
) (
    input  logic                              s_clk,
    input  logic                              arst,
    input  logic [NUM_SOURCES-1:0]            s_tvalid,
    output logic [NUM_SOURCES-1:0]            s_tready,
    input  logic [NUM_SOURCES-1:0]            s_tlast,
    input  logic [USER_WIDTH*NUM_SOURCES-1:0] s_tuser,
    input  logic [DATA_WIDTH*NUM_SOURCES-1:0] s_tdata,
    output logic                              m_tvalid,
    output logic                              m_tlast,
    input  logic                              m_tready,
    output logic [USER_WIDTH-1:0]             m_tuser,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic [SRC_W-1:0]                  m_tdest,
    output logic                              busy,
    output logic                              timeout_err
);

    state_t                 state, nstate;
    logic [SRC_W-1:0]       g, ptr, pick_idx;
    logic [NUM_SOURCES-1:0] pick_gnt, gnt_q;
    logic                   any, sel_valid, sel_last, slice_free, load, ld_last;
    logic [USER_WIDTH-1:0]  ld_user;
    logic [DATA_WIDTH-1:0]  ld_data;

`ifdef AXIS_PKT_ARB_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt;
    logic             tout;
`endif

    axis_arb_pick #(.N(NUM_SOURCES), .SW(SRC_W)) u_pick (
        .req  (s_tvalid),
        .ptr  (ptr),
        .fixed(ARB_MODE == ARB_FIXED),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .any  (any)
    );

    assign busy = state != IDLE;

    always_comb begin
        nstate     = state;
        slice_free = !m_tvalid || m_tready;
        sel_valid  = s_tvalid[g];
        sel_last   = s_tlast[g];
        s_tready   = '0;
        load       = 1'b0;
        ld_last    = sel_last;
        ld_user    = s_tuser[g*USER_WIDTH +: USER_WIDTH];
        ld_data    = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
`ifdef AXIS_PKT_ARB_MUX_TIMEOUT_EN
        tout       = 1'b0;
`endif
        case (state)
            IDLE: nstate = any ? PASS : IDLE;
            PASS: begin
                s_tready = slice_free ? gnt_q : '0;
                load     = sel_valid && slice_free;
                if (load && sel_last)
                    nstate = IDLE;
`ifdef AXIS_PKT_ARB_MUX_TIMEOUT_EN
                else if (!sel_valid && cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    tout   = 1'b1;
                    nstate = FLUSH;
                end
`endif
            end
`ifdef AXIS_PKT_ARB_MUX_TIMEOUT_EN
            // Close the packet downstream with a marker beat, then swallow the rest upstream.
            FLUSH: begin
                load    = slice_free;
                ld_last = 1'b1;
                ld_user = {USER_WIDTH{MARKER_TUSER_BIT}};
                ld_data = '0;
                nstate  = slice_free ? DRAIN : FLUSH;
            end
            DRAIN: begin
                s_tready = gnt_q;
                nstate   = (sel_valid && sel_last) ? IDLE : DRAIN;
            end
`endif
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge s_clk or posedge arst)
        if (arst) state <= IDLE;
        else      state <= nstate;

    always_ff @(posedge s_clk or posedge arst) begin
        if (arst) begin
            g        <= '0;
            gnt_q    <= '0;
            ptr      <= SRC_W'(NUM_SOURCES - 1);
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tuser  <= '0;
            m_tdata  <= '0;
            m_tdest  <= '0;
        end else begin
            if (state == IDLE && any) begin
                g     <= pick_idx;
                gnt_q <= pick_gnt;
                if (ARB_MODE == ARB_RR)
                    ptr <= pick_idx;
            end
            if (load) begin
                m_tvalid <= 1'b1;
                m_tlast  <= ld_last;
                m_tuser  <= ld_user;
                m_tdata  <= ld_data;
                m_tdest  <= g;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

`ifdef AXIS_PKT_ARB_MUX_TIMEOUT_EN
    // Counts consecutive cycles the granted source withholds data mid-packet.
    always_ff @(posedge s_clk or posedge arst) begin
        if (arst) begin
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tout;
            cnt         <= (state == PASS && !sel_valid && !tout) ? cnt + 1'b1 : '0;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_arb_mux.sv
// tb_axis_pkt_arb_mux: directed bench for a round-robin and a fixed-priority instance.
module tb_axis_pkt_arb_mux;

    localparam int N = 4;

    typedef struct {
        logic [1:0]  dest;
        logic        last;
        logic [7:0]  user;
        logic [31:0] data;
        int          cyc;
    } beat_t;

    typedef struct {
        int         fx;
        int         pre;
        logic [3:0] req;
        int         exp;
    } vec_t;

    logic            s_clk = 1'b0;
    logic            arst  = 1'b1;
    logic [N-1:0]    s_tvalid, s_tlast;
    logic [8*N-1:0]  s_tuser;
    logic [32*N-1:0] s_tdata;
    logic            m_tready;

    logic [N-1:0] o_rdy  [2];
    logic         o_mv   [2];
    logic         o_ml   [2];
    logic         o_busy [2];
    logic         o_to   [2];
    logic [7:0]   o_mu   [2];
    logic [31:0]  o_md   [2];
    logic [1:0]   o_dest [2];

    for (genvar i = 0; i < 2; i++) begin : g_dut
        axis_pkt_arb_mux #(
            .DATA_WIDTH(32), .USER_WIDTH(8), .NUM_SOURCES(N),
            .ARB_MODE(i), .TIMEOUT_CYCLES(16)
        ) u_dut (
            .s_clk      (s_clk),
            .arst       (arst),
            .s_tvalid   (s_tvalid),
            .s_tready   (o_rdy[i]),
            .s_tlast    (s_tlast),
            .s_tuser    (s_tuser),
            .s_tdata    (s_tdata),
            .m_tvalid   (o_mv[i]),
            .m_tlast    (o_ml[i]),
            .m_tready   (m_tready),
            .m_tuser    (o_mu[i]),
            .m_tdata    (o_md[i]),
            .m_tdest    (o_dest[i]),
            .busy       (o_busy[i]),
            .timeout_err(o_to[i])
        );
    end

    always #5 s_clk = ~s_clk;

    int       checks = 0, errors = 0;
    int       sel = 0, cyc = 0, to_seen = 0, to_cyc = -1;
    bit [N-1:0] en;
    int       len[N], npk[N], beat[N], pkt[N], gap[N], gap_at[N], gap_n[N];
    beat_t    rec[$];
    beat_t    snap_b;
    logic     snap_mv, snap_busy;
    logic [N-1:0] snap_rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] eb(input int s, input int p, input int b, input bit l);
        return {21'd0, 2'(s), l, 8'(s * 16 + b), 8'(s), 8'(p), 16'(b)};
    endfunction

    function automatic logic [63:0] pk(input beat_t x);
        return {21'd0, x.dest, x.last, x.user, x.data};
    endfunction

    task automatic src(input int i, input int l, input int n);
        en[i] = 1'b1; len[i] = l; npk[i] = n; beat[i] = 0; pkt[i] = 0;
    endtask

    // Drives the source models, samples just before the edge, then advances models on handshakes.
    task automatic cycle();
        logic [N-1:0] acc;
        logic         macc;
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]         = en[i] && gap[i] == 0;
            s_tlast[i]          = beat[i] == len[i] - 1;
            s_tdata[i*32 +: 32] = {8'(i), 8'(pkt[i]), 16'(beat[i])};
            s_tuser[i*8 +: 8]   = 8'(i * 16 + beat[i]);
        end
        #1;
        snap_rdy    = o_rdy[sel];
        snap_mv     = o_mv[sel];
        snap_busy   = o_busy[sel];
        acc         = s_tvalid & o_rdy[sel];
        macc        = o_mv[sel] && m_tready;
        snap_b.dest = o_dest[sel];
        snap_b.last = o_ml[sel];
        snap_b.user = o_mu[sel];
        snap_b.data = o_md[sel];
        @(posedge s_clk);
        cyc++;
        snap_b.cyc = cyc;
        if (macc) rec.push_back(snap_b);
        @(negedge s_clk);
        if (o_to[sel]) begin
            to_seen++;
            to_cyc = cyc;
        end
        for (int i = 0; i < N; i++) begin
            if (gap[i] > 0) gap[i]--;
            else if (acc[i]) begin
                if (beat[i] == len[i] - 1) begin
                    beat[i] = 0;
                    pkt[i]++;
                    if (pkt[i] == npk[i]) en[i] = 1'b0;
                end else beat[i]++;
                if (beat[i] == gap_at[i]) gap[i] = gap_n[i];
            end
        end
    endtask

    task automatic run_until_idle(input int maxc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxc && !ok; k++) begin
            cycle();
            ok = (en == '0) && !o_busy[sel] && !o_mv[sel];
        end
    endtask

    task automatic do_reset(input int s);
        sel = s; arst = 1'b1; m_tready = 1'b1;
        en = '0;
        for (int i = 0; i < N; i++) begin
            len[i] = 1; npk[i] = 1; beat[i] = 0; pkt[i] = 0;
            gap[i] = 0; gap_at[i] = -1; gap_n[i] = 0;
        end
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0;
        rec.delete();
        repeat (2) @(negedge s_clk);
        arst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vt[9];
        bit    ok;
        int    t0, stall_n;
        logic  prev_stall;
        beat_t prev_b;
        logic [0:11] rp;

        vt[0] = '{0, -1, 4'b1010, 1};
        vt[1] = '{1, -1, 4'b1010, 1};
        vt[2] = '{0,  1, 4'b1011, 3};
        vt[3] = '{1,  1, 4'b1011, 0};
        vt[4] = '{0,  3, 4'b0110, 1};
        vt[5] = '{0,  2, 4'b0111, 0};
        vt[6] = '{1,  2, 4'b1100, 2};
        vt[7] = '{0,  0, 4'b0001, 0};
        vt[8] = '{0,  3, 4'b1000, 3};

        // Reset state
        do_reset(0);
        chk("rst_mvalid", o_mv[0], 0);
        chk("rst_busy", o_busy[0], 0);
        chk("rst_sready", o_rdy[0], 0);
        chk("rst_tout", o_to[0], 0);
        chk("rst_mout", {o_ml[0], o_dest[0], o_mu[0], o_md[0]}, 0);
        chk("rst_fx_mvalid", o_mv[1], 0);

        // Single 8-beat packet on source 2
        src(2, 8, 1);
        t0 = cyc + 1;
        run_until_idle(40, ok);
        chk("single_done", ok, 1);
        chk("single_count", rec.size(), 8);
        for (int j = 0; j < 8; j++) chk($sformatf("single_beat%0d", j), pk(rec[j]), eb(2, 0, j, j == 7));
        chk("single_first_cyc", rec[0].cyc, t0 + 2);
        chk("single_last_cyc", rec[7].cyc, t0 + 9);

        // Round-robin with all sources offering 2-beat packets back to back
        do_reset(0);
        for (int i = 0; i < N; i++) src(i, 2, 2);
        t0 = cyc + 1;
        run_until_idle(80, ok);
        chk("rr_done", ok, 1);
        chk("rr_count", rec.size(), 16);
        for (int p = 0; p < 8; p++)
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("rr_p%0d_b%0d", p, j), pk(rec[2*p+j]), eb(p % 4, p / 4, j, j == 1));
                chk($sformatf("rr_p%0d_b%0d_cyc", p, j), rec[2*p+j].cyc, t0 + 2 + 3*p + j);
            end

        // Fixed priority: source 1 beats source 3 until it stops requesting
        do_reset(1);
        src(1, 2, 3);
        src(3, 2, 1);
        run_until_idle(60, ok);
        chk("fx_done", ok, 1);
        chk("fx_count", rec.size(), 8);
        for (int p = 0; p < 4; p++)
            for (int j = 0; j < 2; j++)
                chk($sformatf("fx_p%0d_b%0d", p, j), pk(rec[2*p+j]),
                    eb(p < 3 ? 1 : 3, p < 3 ? p : 0, j, j == 1));

        // Backpressure 1,0,0,1 mid-packet
        do_reset(0);
        src(0, 4, 1);
        rp = 12'b111001111111;
        stall_n = 0;
        prev_stall = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            m_tready = (k < 12) ? rp[k] : 1'b1;
            cycle();
            if (snap_busy) chk($sformatf("bp_rdy_k%0d", k), snap_rdy, {3'b000, !snap_mv || m_tready});
            if (prev_stall) begin
                stall_n++;
                chk($sformatf("bp_hold_k%0d", k), pk(snap_b), pk(prev_b));
            end
            prev_stall = snap_mv && !m_tready;
            prev_b = snap_b;
            ok = (en == '0) && !o_busy[sel] && !o_mv[sel];
        end
        chk("bp_done", ok, 1);
        chk("bp_stalls", stall_n, 2);
        chk("bp_count", rec.size(), 4);
        for (int j = 0; j < 4; j++) chk($sformatf("bp_beat%0d", j), pk(rec[j]), eb(0, 0, j, j == 3));
`ifndef AXIS_PKT_ARB_MUX_TIMEOUT_EN
        chk("no_timeout_pulse", to_seen, 0);
`endif

        // Asynchronous reset mid-packet
        do_reset(0);
        src(0, 6, 1);
        for (int k = 0; k < 20 && rec.size() < 2; k++) cycle();
        chk("arst_pre_mvalid", o_mv[0], 1);
        arst = 1'b1;
        #1;
        chk("arst_mvalid", o_mv[0], 0);
        chk("arst_busy", o_busy[0], 0);
        chk("arst_sready", o_rdy[0], 0);
        en = '0;
        @(negedge s_clk);
        arst = 1'b0;
        rec.delete();
        src(0, 1, 1);
        src(1, 1, 1);
        run_until_idle(30, ok);
        chk("arst_after_done", ok, 1);
        chk("arst_first_dest", rec[0].dest, 0);
        chk("arst_second_dest", rec[1].dest, 1);

        // Arbitration table: optional priming packet, then a request pattern in IDLE
        foreach (vt[v]) begin
            do_reset(vt[v].fx);
            if (vt[v].pre >= 0) begin
                src(vt[v].pre, 1, 1);
                run_until_idle(20, ok);
                chk($sformatf("vec%0d_pre_done", v), ok, 1);
            end
            rec.delete();
            for (int i = 0; i < N; i++) if (vt[v].req[i]) src(i, 1, 1);
            run_until_idle(40, ok);
            chk($sformatf("vec%0d_done", v), ok, 1);
            chk($sformatf("vec%0d_first_dest", v), rec[0].dest, vt[v].exp);
        end

`ifdef AXIS_PKT_ARB_MUX_TIMEOUT_EN
        // Stall timeout: 3 beats, 20 idle cycles, 2 late beats ending the packet
        do_reset(0);
        src(0, 5, 1);
        gap_at[0] = 3;
        gap_n[0]  = 20;
        to_seen   = 0;
        t0 = cyc + 1;
        run_until_idle(80, ok);
        chk("to_done", ok, 1);
        chk("to_pulses", to_seen, 1);
        chk("to_pulse_cyc", to_cyc, t0 + 19);
        chk("to_count", rec.size(), 4);
        for (int j = 0; j < 3; j++) chk($sformatf("to_beat%0d", j), pk(rec[j]), eb(0, 0, j, 0));
        chk("to_marker", pk(rec[3]), {21'd0, 2'd0, 1'b1, 8'hFF, 32'd0});
        chk("to_marker_cyc", rec[3].cyc, t0 + 21);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
